// File: rtl/hazard_ctrl_mc.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_mc
//
// Hazard and pipeline-control unit for the 5-stage F/D/E/M/W ARM pipeline.
// Drives every pipeline-register enable (stall_*) and bubble (flush_*) and
// selects the operand forwarding path for each execute-stage source port.
//
// On top of the classic two-source forwarding/stall scheme it supports:
//   * NSRC source-register ports per instruction,
//   * a parametrised register-address width,
//   * variable-latency data memory (mem_ack handshake) with a wait-timeout
//     FSM that raises a sticky mem_err,
//   * two saturating performance counters (stall cycles, flush cycles).
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   src_d / src_e       NSRC packed source register numbers in D / E
//                       (port i at [i*RA_W +: RA_W])
//   src_valid_d/_e      per-port "operand is really read" flags
//   dst_e/_m/_w         destination register numbers in E / M / W
//   reg_write_e/_m/_w   register-file write enables in E / M / W
//   memtoreg_e          E holds a load
//   branch_taken_e      branch resolved taken in E
//   mem_req_m, mem_ack  data-memory request in M / completion this cycle
//   clr_counters        synchronous clear of both performance counters
//   forward_e           2 bits per port: 00 regfile, 10 ALUOutM, 01 ResultW
//   stall_f/_d/_e/_m    hold PC, F/D, D/E, E/M registers
//   flush_d/_e/_w       bubble into F/D, D/E, M/W registers
//   mem_err             sticky memory-timeout flag
//   stall_cycles        saturating count of cycles with stall_f high
//   flush_count         saturating count of cycles with flush_d or flush_e high
// -----------------------------------------------------------------------------
module hazard_ctrl_mc #(
   parameter int NSRC        = 2,
   parameter int RA_W        = 4,
   parameter int PC_IDX      = 15,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC*RA_W-1:0] src_d,
   input  logic [NSRC*RA_W-1:0] src_e,
   input  logic [NSRC-1:0]      src_valid_e,
   input  logic [NSRC-1:0]      src_valid_d,
   input  logic [RA_W-1:0]      dst_e,
   input  logic [RA_W-1:0]      dst_m,
   input  logic [RA_W-1:0]      dst_w,
   input  logic                 reg_write_e,
   input  logic                 reg_write_m,
   input  logic                 reg_write_w,
   input  logic                 memtoreg_e,
   input  logic                 branch_taken_e,
   input  logic                 mem_req_m,
   input  logic                 mem_ack,
   input  logic                 clr_counters,
   output logic [2*NSRC-1:0]    forward_e,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 stall_e,
   output logic                 stall_m,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic                 flush_w,
   output logic                 mem_err,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_count
);

   // Wait counter must be able to hold MEM_TIMEOUT itself.
   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [RA_W-1:0]   PC_REG   = RA_W'(PC_IDX);
   localparam logic [WCNT_W-1:0] TO_VAL   = WCNT_W'(MEM_TIMEOUT);
   localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
   logic              mem_err_reg, mem_err_next;
   logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
   logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;

   logic [NSRC-1:0]   ld_hit;
   logic              ldstall;
   logic              memstall;

   // --------------------------------------------------------------------------
   // Forwarding: one independent selector per execute-stage source port.
   // The PC is never forwarded because its value is produced by the fetch
   // path, not by the ALU/result bus. M beats W since it is the younger write.
   // --------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_fwd
         logic [RA_W-1:0] src;
         logic            eligible;

         assign src      = src_e[gi*RA_W +: RA_W];
         assign eligible = src_valid_e[gi] && (src != PC_REG);

         always_comb begin
            forward_e[2*gi +: 2] = 2'b00;
            if (eligible && reg_write_m && (dst_m == src)) begin
               forward_e[2*gi +: 2] = 2'b10;
            end else if (eligible && reg_write_w && (dst_w == src)) begin
               forward_e[2*gi +: 2] = 2'b01;
            end
         end
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Load-use detection: the load in E would be consumed by a decode-stage
   // source before the data returns from memory.
   // --------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_ld
         assign ld_hit[gi] = src_valid_d[gi] && (src_d[gi*RA_W +: RA_W] == dst_e);
      end
   endgenerate

   assign ldstall  = memtoreg_e && reg_write_e && (dst_e != PC_REG) && (|ld_hit);

   // The ack is used combinationally so the freeze lifts in the ack cycle.
   assign memstall = mem_req_m && !mem_ack;

   // --------------------------------------------------------------------------
   // Stall/flush equations. A memory wait freezes the whole pipeline, so any
   // branch or load-use bubble is held off; the frozen E instruction simply
   // raises it again once the access completes. A branch coinciding with a
   // load-use raises both stall_d and flush_d; the register gives flush
   // priority, which discards the wrong-path instruction in D.
   // --------------------------------------------------------------------------
   assign stall_e = memstall;
   assign stall_m = memstall;
   assign flush_w = memstall;
   assign stall_f = memstall || ldstall;
   assign stall_d = memstall || ldstall;
   assign flush_e = !memstall && (ldstall || branch_taken_e);
   assign flush_d = !memstall && branch_taken_e;

   // --------------------------------------------------------------------------
   // Memory-wait FSM. wcnt holds the number of consecutive wait cycles already
   // completed and saturates at MEM_TIMEOUT; reaching that value latches
   // mem_err until reset. The stall outputs never look at this FSM.
   // --------------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      wcnt_next    = wcnt_reg;
      mem_err_next = mem_err_reg;

      case (state_reg)
         IDLE: begin
            if (memstall) begin
               state_next = WAIT;
               wcnt_next  = WCNT_ONE;
            end
         end
         WAIT: begin
            if (mem_ack || !mem_req_m) begin
               state_next = IDLE;
               wcnt_next  = '0;
            end else if (wcnt_reg != TO_VAL) begin
               wcnt_next = wcnt_reg + WCNT_ONE;
            end
         end
         default: begin
            state_next = IDLE;
            wcnt_next  = '0;
         end
      endcase

      if (wcnt_next == TO_VAL) begin
         mem_err_next = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Performance counters: clear beats increment, both saturate at all-ones.
   // --------------------------------------------------------------------------
   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      flush_cnt_next = flush_cnt_reg;

      if (clr_counters) begin
         stall_cnt_next = '0;
      end else if (stall_f && (stall_cnt_reg != CNT_MAX)) begin
         stall_cnt_next = stall_cnt_reg + CNT_ONE;
      end

      if (clr_counters) begin
         flush_cnt_next = '0;
      end else if ((flush_d || flush_e) && (flush_cnt_reg != CNT_MAX)) begin
         flush_cnt_next = flush_cnt_reg + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         wcnt_reg      <= '0;
         mem_err_reg   <= 1'b0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         wcnt_reg      <= wcnt_next;
         mem_err_reg   <= mem_err_next;
         stall_cnt_reg <= stall_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
      end
   end

   assign mem_err      = mem_err_reg;
   assign stall_cycles = stall_cnt_reg;
   assign flush_count  = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_mc
//
// Directed bench for hazard_ctrl_mc (NSRC=2, RA_W=4, PC_IDX=15,
// MEM_TIMEOUT=4, CNT_W=3). A rule-level reference model predicts every output;
// a compare process checks the DUT against it on every falling edge, and the
// directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_mc;

   localparam int NSRC = 2;
   localparam int RA_W = 4;
   localparam int PC   = 15;
   localparam int TO   = 4;
   localparam int CW   = 3;
   localparam int CMAX = 7;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NSRC*RA_W-1:0] src_d, src_e;
   logic [NSRC-1:0]      src_valid_e, src_valid_d;
   logic [RA_W-1:0]      dst_e, dst_m, dst_w;
   logic                 reg_write_e, reg_write_m, reg_write_w;
   logic                 memtoreg_e, branch_taken_e, mem_req_m, mem_ack, clr_counters;
   logic [2*NSRC-1:0]    forward_e;
   logic                 stall_f, stall_d, stall_e, stall_m;
   logic                 flush_d, flush_e, flush_w, mem_err;
   logic [CW-1:0]        stall_cycles, flush_count;

   int n_assert = 0;
   int n_fail   = 0;
   logic check_en = 1'b0;

   always #5 clk = ~clk;

   hazard_ctrl_mc #(
      .NSRC(NSRC), .RA_W(RA_W), .PC_IDX(PC), .MEM_TIMEOUT(TO), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset),
      .src_d(src_d), .src_e(src_e),
      .src_valid_e(src_valid_e), .src_valid_d(src_valid_d),
      .dst_e(dst_e), .dst_m(dst_m), .dst_w(dst_w),
      .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .memtoreg_e(memtoreg_e), .branch_taken_e(branch_taken_e),
      .mem_req_m(mem_req_m), .mem_ack(mem_ack), .clr_counters(clr_counters),
      .forward_e(forward_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
      .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [2*NSRC-1:0] e_fwd;
   logic e_ld, e_ms, e_stall, e_fl_d, e_fl_e;
   int   m_sc, m_fc, m_run, m_run_next;
   logic m_err;

   always_comb begin
      logic hit;
      e_fwd = '0;
      hit   = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (src_valid_e[i] && int'(src_e[i*RA_W +: RA_W]) != PC) begin
            if (reg_write_m && dst_m == src_e[i*RA_W +: RA_W])      e_fwd[2*i +: 2] = 2'b10;
            else if (reg_write_w && dst_w == src_e[i*RA_W +: RA_W]) e_fwd[2*i +: 2] = 2'b01;
         end
         if (src_valid_d[i] && src_d[i*RA_W +: RA_W] == dst_e) hit = 1'b1;
      end
      e_ld    = memtoreg_e && reg_write_e && int'(dst_e) != PC && hit;
      e_ms    = mem_req_m && !mem_ack;
      e_stall = e_ms || e_ld;
      e_fl_e  = !e_ms && (e_ld || branch_taken_e);
      e_fl_d  = !e_ms && branch_taken_e;
      // length of the current run of consecutive wait cycles, capped
      m_run_next = e_ms ? ((m_run < TO) ? m_run + 1 : m_run) : 0;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_sc <= 0; m_fc <= 0; m_run <= 0; m_err <= 1'b0;
      end else begin
         m_run <= m_run_next;
         if (m_run_next == TO) m_err <= 1'b1;
         if (clr_counters)                 m_sc <= 0;
         else if (e_stall && m_sc < CMAX)  m_sc <= m_sc + 1;
         if (clr_counters)                          m_fc <= 0;
         else if ((e_fl_d || e_fl_e) && m_fc < CMAX) m_fc <= m_fc + 1;
      end
   end

   always @(negedge clk) begin
      if (check_en && !reset) begin
         chk("m_forward_e",    int'(forward_e),    int'(e_fwd));
         chk("m_stall_f",      int'(stall_f),      int'(e_stall));
         chk("m_stall_d",      int'(stall_d),      int'(e_stall));
         chk("m_stall_e",      int'(stall_e),      int'(e_ms));
         chk("m_stall_m",      int'(stall_m),      int'(e_ms));
         chk("m_flush_w",      int'(flush_w),      int'(e_ms));
         chk("m_flush_d",      int'(flush_d),      int'(e_fl_d));
         chk("m_flush_e",      int'(flush_e),      int'(e_fl_e));
         chk("m_mem_err",      int'(mem_err),      int'(m_err));
         chk("m_stall_cycles", int'(stall_cycles), m_sc);
         chk("m_flush_count",  int'(flush_count),  m_fc);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic go();
      @(posedge clk); #2;
   endtask

   task automatic mid();
      @(negedge clk); #1;
   endtask

   task automatic clr_in();
      src_d = '0; src_e = '0; src_valid_e = '0; src_valid_d = '0;
      dst_e = '0; dst_m = '0; dst_w = '0;
      reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
      memtoreg_e = 0; branch_taken_e = 0; mem_req_m = 0; mem_ack = 0; clr_counters = 0;
   endtask

   task automatic set_ld();
      memtoreg_e = 1; reg_write_e = 1; dst_e = 4'd5; src_d = 8'h50; src_valid_d = 2'b10;
   endtask

   initial begin
      reset = 1'b1;
      clr_in();
      #3;
      chk("rst_forward_e", int'(forward_e), 0);
      chk("rst_stalls", int'({stall_f, stall_d, stall_e, stall_m}), 0);
      chk("rst_flushes", int'({flush_d, flush_e, flush_w}), 0);
      chk("rst_regs", int'({mem_err, stall_cycles, flush_count}), 0);
      go();
      reset = 1'b0;
      check_en = 1'b1;

      // forwarding
      go(); dst_m = 3; reg_write_m = 1; dst_w = 3; reg_write_w = 1; src_e = 8'h03; src_valid_e = 2'b01;
      mid(); chk("fwd_m_prio", int'(forward_e), 4'b0010);
      go(); reg_write_m = 0;
      mid(); chk("fwd_w", int'(forward_e), 4'b0001);
      go(); reg_write_m = 1; src_e = 8'h0F;
      mid(); chk("fwd_pc", int'(forward_e), 0);
      go(); src_e = 8'h30; src_valid_e = 2'b10;
      mid(); chk("fwd_port1", int'(forward_e), 4'b1000);

      // load-use
      go(); clr_in(); set_ld();
      mid(); chk("ld_stall_fd", int'({stall_f, stall_d, flush_e, flush_d}), 4'b1110);
             chk("ld_stall_em", int'({stall_e, stall_m, flush_w}), 0);
      go(); chk("ld_stall_cnt", int'(stall_cycles), 1);
            chk("ld_flush_cnt", int'(flush_count), 1);
      src_valid_d = 2'b00;
      mid(); chk("ld_invalid", int'({stall_f, stall_d, flush_e, flush_d}), 0);
      go(); chk("ld_invalid_cnt", int'(stall_cycles), 1);

      // branch together with load-use
      src_valid_d = 2'b10; branch_taken_e = 1;
      mid(); chk("br_ld", int'({flush_d, flush_e, stall_d}), 3'b111);
      go(); chk("br_flush_cnt", int'(flush_count), 2);
            chk("br_stall_cnt", int'(stall_cycles), 2);
      clr_in();

      // memory wait of 3 cycles with a concurrent branch
      mem_req_m = 1; branch_taken_e = 1;
      for (int k = 0; k < 3; k++) begin
         mid(); chk("mw_stall", int'({stall_f, stall_d, stall_e, stall_m, flush_w}), 5'b11111);
                chk("mw_noflush", int'({flush_d, flush_e}), 0);
         go();
      end
      mem_ack = 1;
      mid(); chk("mw_ack_stall", int'({stall_f, stall_d, stall_e, stall_m, flush_w}), 0);
             chk("mw_ack_flush", int'({flush_d, flush_e}), 2'b11);
             chk("mw_no_err", int'(mem_err), 0);
      go(); chk("mw_stall_cnt", int'(stall_cycles), 5);
            chk("mw_flush_cnt", int'(flush_count), 3);
      clr_in();

      // counter saturation and clear priority
      clr_counters = 1;
      go(); chk("clr_stall", int'(stall_cycles), 0);
            chk("clr_flush", int'(flush_count), 0);
      clr_counters = 0; set_ld();
      repeat (10) go();
      chk("sat_stall", int'(stall_cycles), 7);
      chk("sat_flush", int'(flush_count), 7);
      clr_counters = 1;
      go(); chk("clr_prio", int'(stall_cycles), 0);
      clr_in();

      // timeout
      mem_req_m = 1;
      for (int k = 1; k <= 4; k++) begin
         go(); chk("to_err", int'(mem_err), (k >= 4) ? 1 : 0);
      end
      mem_ack = 1;
      go(); clr_in();
      go(); chk("to_sticky", int'(mem_err), 1);

      // asynchronous reset in the middle of a wait
      mem_req_m = 1;
      go(); go();
      mid(); reset = 1'b1; #1;
      chk("arst_err", int'(mem_err), 0);
      chk("arst_cnt", int'({stall_cycles, flush_count}), 0);
      clr_in();
      go(); reset = 1'b0;

      // mixed vectors checked by the model
      for (int k = 0; k < 80; k++) begin
         go();
         src_d = 8'($urandom); src_e = 8'($urandom);
         src_valid_d = 2'($urandom); src_valid_e = 2'($urandom);
         dst_e = 4'($urandom_range(4, 6)); dst_m = 4'($urandom); dst_w = 4'($urandom);
         reg_write_e = 1'($urandom); reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
         memtoreg_e = 1'($urandom); branch_taken_e = 1'($urandom);
         mem_req_m = 1'($urandom); mem_ack = ($urandom_range(0, 3) == 0);
         clr_counters = ($urandom_range(0, 15) == 0);
      end
      go(); clr_in();
      go();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
